ws_pixel_stream_apb: RTL and testbench
======================================

Name: ws_pixel_stream_apb

Overview:
APB3 slave that buffers 24-bit GRB pixel words from the processor in a FIFO and streams them, one frame at a time, to the downstream WS2812 bit serializer over a valid/ready handshake. After the last pixel of a frame it enforces the LED latch (reset) gap before another frame can start. Sits on the APB bus directly upstream of the LED bit-encoder stage.

Parameters:
DEPTH, 16, FIFO depth in pixels; power of 2, 2..128
LATCH_CYCLES, 5000, PCLK cycles of idle gap after a frame's last pixel handshake (>=1)

Ports:
PCLK  in  1  clock
PRESERN  in  1  synchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write/read
PADDR  in  32  APB address; only PADDR[3:2] decoded
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  tied 1
PSLVERR  out  1  APB error
pix_data  out  24  pixel to serializer, GRB, MSB sent first
pix_valid  out  1  pix_data valid
pix_ready  in  1  serializer accepts pixel
pix_last  out  1  qualifies final pixel of frame
busy  out  1  frame streaming or latch gap active

Behaviour:
- Reset (PRESERN=0 at PCLK edge, any state incl. mid-frame): FIFO emptied, state IDLE, gap counter 0, all sticky flags 0, IRQ enable 0, COUNT 0; PRDATA=0, PSLVERR=0, pix_valid=0, pix_last=0, busy=0, pix_data=0.
- APB write takes effect on the edge where PSEL&PENABLE&PWRITE=1. PRDATA is combinational on PSEL&~PWRITE from the decoded register; otherwise 0. PREADY always 1; no wait states.
- Register map:
  0x0 DATA (W): push PWDATA[23:0]. Reads return 0.
  0x4 CTRL (R/W): bit0 START (write-only, self-clearing); bit1 FLUSH (write-only); bit2 IRQ_ENABLE; [15:8] COUNT. Reads return IRQ_ENABLE and the stored COUNT.
  0x8 STATUS (R, W1C on [13:11]): [7:0] fill level; 8 empty; 9 full; 10 busy; 11 overflow; 12 underrun (not W1C, live); 13 done.
  0xC reserved: reads 0, writes ignored.
- Push when full: data dropped, overflow set, PSLVERR=1 during that access phase only. Full is evaluated on pre-pop state: a same-cycle pop does not admit a push to a full FIFO. Push plus pop on a non-full FIFO leaves level unchanged.
- FSM IDLE/STREAM/LATCH:
  IDLE: START with COUNT!=0 loads remaining=COUNT, moves to STREAM next cycle. START with COUNT=0 is ignored. FLUSH empties the FIFO (IDLE only; ignored elsewhere).
  STREAM: pix_valid = ~empty; pix_data = FIFO head; pix_last = pix_valid & (remaining==1). Handshake (valid&ready) pops and decrements remaining. Handshake with remaining==1 moves to LATCH and loads gap=LATCH_CYCLES. Each STREAM cycle with FIFO empty sets underrun as a live flag; it is cleared by the next handshake or on leaving STREAM. pix_data stays stable while valid&~ready.
  LATCH: pix_valid=0; gap decrements each cycle; at gap==1, next state is IDLE and done is set.
- busy=1 in STREAM or LATCH. START while busy is ignored; COUNT still updates. Pushes are accepted in every state.
- Simultaneous W1C of done and setting of done in the same cycle: the set wins.
- Fill-level width is clog2(DEPTH)+1, zero-extended into [7:0].

Optional Feature:
WS_PIXSTREAM_IRQ_EN: when defined, adds output irq (1 bit, registered, reset 0) = IRQ_ENABLE & (done | overflow), updated the cycle after the flags change. When undefined, there is no irq port; the IRQ_ENABLE bit is still stored and readable but has no effect.

Test Plan:
- Reset, read STATUS -> 0x00000100 (empty, level 0); pix_valid=0, busy=0.
- Push 3 pixels 0x0000FF/0x00FF00/0xFF0000, CTRL COUNT=3 START, pix_ready=1 -> 3 handshakes in order, pix_last on the 3rd only, busy held LATCH_CYCLES more, STATUS.done=1.
- DEPTH=16: push 17 words -> 17th access PSLVERR=1, STATUS level=16 with full and overflow set; W1C 0x800 clears overflow.
- COUNT=4 with 2 pixels queued -> 2 handshakes, then underrun=1 and pix_valid=0; push 2 more -> stream completes, done=1.
- pix_ready low for 5 cycles mid-frame -> pix_data/pix_valid stable; PRESERN=0 mid-STREAM -> next cycle IDLE, FIFO empty, busy=0.
- WS_PIXSTREAM_IRQ_EN defined, IRQ_ENABLE=1, 1-pixel frame -> irq rises 1 cycle after done; W1C done -> irq falls.

Source files
------------

// File: rtl/ws_pixel_stream_apb.sv
// rtl/ws_pixel_stream_apb.sv - APB3 pixel FIFO streaming GRB frames to a WS2812 serializer (optional irq: WS_PIXSTREAM_IRQ_EN)
module ws_pixel_stream_apb #(
    parameter int DEPTH        = 16,
    parameter int LATCH_CYCLES = 5000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy
`ifdef WS_PIXSTREAM_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_LATCH  = 2'd2
    } state_t;

    state_t         state_q;
    logic [7:0]     remaining_q;
    logic [GW-1:0]  gap_q;
    logic [23:0]    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic           overflow_q;
    logic           underrun_q;
    logic           done_q;
    logic           irq_en_q;
    logic [7:0]     count_q;

    logic [PW-1:0]  level;
    logic [7:0]     level8;
    logic           empty;
    logic           full;
    logic           wr_en;
    logic           sel_data;
    logic           sel_ctrl;
    logic           sel_status;
    logic           push_req;
    logic           push_ok;
    logic           pop;
    logic           start;
    logic           flush;
    logic           done_set;
    logic           unused_bits;

    assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:24]};

    assign level  = wr_ptr_q - rd_ptr_q;
    assign level8 = 8'(level);
    assign empty  = (level == '0);
    assign full   = (level == PW'(DEPTH));

    assign wr_en      = PSEL & PENABLE & PWRITE;
    assign sel_data   = (PADDR[3:2] == 2'd0);
    assign sel_ctrl   = (PADDR[3:2] == 2'd1);
    assign sel_status = (PADDR[3:2] == 2'd2);

    // Full is judged on the pre-pop level, so a same-cycle pop never admits a push
    assign push_req = wr_en & sel_data;
    assign push_ok  = push_req & ~full;
    assign pop      = pix_valid & pix_ready;
    assign start    = wr_en & sel_ctrl & PWDATA[0] & (state_q == S_IDLE) & (PWDATA[15:8] != 8'd0);
    assign flush    = wr_en & sel_ctrl & PWDATA[1] & (state_q == S_IDLE);
    assign done_set = (state_q == S_LATCH) & (gap_q == GW'(1));

    assign PREADY    = 1'b1;
    assign PSLVERR   = push_req & full;
    assign busy      = (state_q != S_IDLE);
    assign pix_valid = (state_q == S_STREAM) & ~empty;
    assign pix_last  = pix_valid & (remaining_q == 8'd1);
    assign pix_data  = pix_valid ? mem_q[rd_ptr_q[AW-1:0]] : 24'd0;

    // Combinational read mux; only driven during APB reads
    always_comb begin
        PRDATA = 32'd0;
        if (PSEL && !PWRITE) begin
            case (PADDR[3:2])
                2'd1:    PRDATA = {16'd0, count_q, 5'd0, irq_en_q, 2'b00};
                2'd2:    PRDATA = {18'd0, done_q, underrun_q, overflow_q, busy, full, empty, level8};
                default: PRDATA = 32'd0;
            endcase
        end
    end

    // Pixel storage; contents are don't-care until written, so no reset
    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= PWDATA[23:0];
        end
    end

    // FIFO pointers: flush only reachable from IDLE, where no pop can occur
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Frame sequencer: IDLE -> STREAM (COUNT pixels) -> LATCH (idle gap) -> IDLE
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state_q     <= S_IDLE;
            remaining_q <= 8'd0;
            gap_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        remaining_q <= PWDATA[15:8];
                        state_q     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (pop) begin
                        remaining_q <= remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            gap_q   <= GW'(LATCH_CYCLES);
                            state_q <= S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    gap_q <= gap_q - GW'(1);
                    if (gap_q == GW'(1)) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Control register and status flags; a same-cycle set beats a W1C
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            if (wr_en && sel_ctrl) begin
                irq_en_q <= PWDATA[2];
                count_q  <= PWDATA[15:8];
            end
            if (push_req && full)                        overflow_q <= 1'b1;
            else if (wr_en && sel_status && PWDATA[11])  overflow_q <= 1'b0;
            if (done_set)                                done_q <= 1'b1;
            else if (wr_en && sel_status && PWDATA[13])  done_q <= 1'b0;
            if (state_q == S_STREAM && empty)            underrun_q <= 1'b1;
            else if (pop || state_q != S_STREAM)         underrun_q <= 1'b0;
        end
    end

`ifdef WS_PIXSTREAM_IRQ_EN
    logic irq_q;
    assign irq = irq_q;

    // Interrupt follows the flags one cycle later
    always_ff @(posedge PCLK) begin
        if (!PRESERN) irq_q <= 1'b0;
        else          irq_q <= irq_en_q & (done_q | overflow_q);
    end
`endif

endmodule

// File: tb/tb_ws_pixel_stream_apb.sv
// tb/tb_ws_pixel_stream_apb.sv - directed self-checking bench for ws_pixel_stream_apb
`timescale 1ns/1ps
module tb_ws_pixel_stream_apb;

    localparam int LAT = 12;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = 32'd0, PWDATA = 32'd0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [23:0] pix_data;
    logic        pix_valid, pix_last, busy;
    logic        pix_ready = 1'b0;
`ifdef WS_PIXSTREAM_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    ws_pixel_stream_apb #(.DEPTH(16), .LATCH_CYCLES(LAT)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
        .busy(busy)
`ifdef WS_PIXSTREAM_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 PCLK = ~PCLK;

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        PRESERN = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESERN = 1'b1;
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", pix_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (pix_data !== 24'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", pix_data); end
        checks++; if (PRDATA !== 32'd0 || PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_apb prdata=%h slverr=%b exp=0/0", PRDATA, PSLVERR); end
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_0100) begin errors++; $display("FAIL reset_status got=%h exp=00000100", r); end
    endtask

    task automatic test_frame();
        logic e;
        logic [31:0] r;
        logic [23:0] hd[4];
        logic        hl[4];
        int n = 0, lat = 0, c;
        apb_write(32'h0, 32'h0000FF, e);
        apb_write(32'h0, 32'h00FF00, e);
        apb_write(32'h0, 32'hFF0000, e);
        pix_ready = 1'b1;
        apb_write(32'h4, 32'h0301, e);
        for (c = 0; c < 200; c++) begin
            if (!busy) break;
            if (pix_valid && pix_ready) begin
                if (n < 4) begin hd[n] = pix_data; hl[n] = pix_last; end
                n++;
            end else if (n == 3) lat++;
            @(posedge PCLK); #1;
        end
        checks++; if (c >= 200) begin errors++; $display("FAIL frame_timeout cycles=%0d limit=200", c); end
        checks++; if (n != 3) begin errors++; $display("FAIL frame_handshakes got=%0d exp=3", n); end
        if (n == 3) begin
            checks++; if ({hd[0], hd[1], hd[2]} !== {24'h0000FF, 24'h00FF00, 24'hFF0000}) begin errors++; $display("FAIL frame_data got=%h %h %h exp=0000ff 00ff00 ff0000", hd[0], hd[1], hd[2]); end
            checks++; if ({hl[0], hl[1], hl[2]} !== 3'b001) begin errors++; $display("FAIL frame_last got=%b%b%b exp=001", hl[0], hl[1], hl[2]); end
        end
        checks++; if (lat != LAT) begin errors++; $display("FAIL frame_latch_gap got=%0d exp=%0d", lat, LAT); end
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_2100) begin errors++; $display("FAIL frame_done_status got=%h exp=00002100", r); end
        apb_write(32'h8, 32'h2000, e);
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_0100) begin errors++; $display("FAIL done_w1c got=%h exp=00000100", r); end
    endtask

    task automatic test_overflow();
        logic e;
        logic early = 1'b0;
        logic [31:0] r;
        for (int i = 0; i < 16; i++) begin
            apb_write(32'h0, 32'(i + 1), e);
            if (e !== 1'b0) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL ovf_early_slverr got=1 exp=0"); end
        apb_write(32'h0, 32'hABCDEF, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ovf_slverr got=%b exp=1", e); end
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_0A10) begin errors++; $display("FAIL ovf_status got=%h exp=00000a10", r); end
        apb_write(32'h8, 32'h0800, e);
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_0210) begin errors++; $display("FAIL ovf_w1c got=%h exp=00000210", r); end
        apb_write(32'h4, 32'h0002, e);
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_0100) begin errors++; $display("FAIL flush_status got=%h exp=00000100", r); end
    endtask

    task automatic test_underrun_stall();
        logic e;
        logic stable = 1'b1;
        logic [31:0] r;
        logic [23:0] hd[4];
        logic        hl[4];
        int n = 0, c;
        pix_ready = 1'b1;
        apb_write(32'h0, 32'h111111, e);
        apb_write(32'h0, 32'h222222, e);
        apb_write(32'h4, 32'h0401, e);
        for (int i = 0; i < 8; i++) begin
            if (pix_valid && pix_ready) n++;
            @(posedge PCLK); #1;
        end
        checks++; if (n != 2) begin errors++; $display("FAIL under_handshakes got=%0d exp=2", n); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL under_valid got=%b exp=0", pix_valid); end
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_1500) begin errors++; $display("FAIL under_status got=%h exp=00001500", r); end
        pix_ready = 1'b0;
        apb_write(32'h0, 32'h333333, e);
        apb_write(32'h0, 32'h444444, e);
        checks++; if (pix_valid !== 1'b1 || pix_data !== 24'h333333) begin errors++; $display("FAIL stall_head valid=%b data=%h exp=1/333333", pix_valid, pix_data); end
        for (int i = 0; i < 5; i++) begin
            @(posedge PCLK); #1;
            if (pix_valid !== 1'b1 || pix_data !== 24'h333333) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable got=0 exp=1"); end
        pix_ready = 1'b1;
        n = 0;
        for (c = 0; c < 200; c++) begin
            if (!busy) break;
            if (pix_valid && pix_ready) begin
                if (n < 4) begin hd[n] = pix_data; hl[n] = pix_last; end
                n++;
            end
            @(posedge PCLK); #1;
        end
        checks++; if (c >= 200 || n != 2) begin errors++; $display("FAIL resume_handshakes got=%0d cycles=%0d exp=2", n, c); end
        if (n == 2) begin
            checks++; if ({hd[0], hd[1], hl[0], hl[1]} !== {24'h333333, 24'h444444, 2'b01}) begin errors++; $display("FAIL resume_data got=%h %h last=%b%b exp=333333 444444 01", hd[0], hd[1], hl[0], hl[1]); end
        end
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_2100) begin errors++; $display("FAIL resume_done got=%h exp=00002100", r); end
        apb_write(32'h8, 32'h2000, e);
    endtask

    task automatic test_regs();
        logic e;
        logic [31:0] r;
        apb_write(32'h4, 32'h0504, e);
        apb_read(32'h4, r);
        checks++; if (r !== 32'h0000_0504) begin errors++; $display("FAIL ctrl_readback got=%h exp=00000504", r); end
        apb_write(32'h0, 32'h555555, e);
        apb_write(32'h4, 32'h0001, e);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_count0 busy=%b exp=0", busy); end
        apb_read(32'h0, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL data_read got=%h exp=0", r); end
        apb_write(32'hC, 32'hFFFF_FFFF, e);
        apb_read(32'hC, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL reserved_read got=%h exp=0", r); end
        apb_write(32'h4, 32'h0002, e);
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_0100) begin errors++; $display("FAIL regs_flush got=%h exp=00000100", r); end
    endtask

`ifdef WS_PIXSTREAM_IRQ_EN
    task automatic test_irq();
        logic e;
        int c;
        pix_ready = 1'b1;
        apb_write(32'h0, 32'h0A0B0C, e);
        apb_write(32'h4, 32'h0105, e);
        for (c = 0; c < 200; c++) begin
            if (!busy) break;
            @(posedge PCLK); #1;
        end
        checks++; if (c >= 200 || irq !== 1'b0) begin errors++; $display("FAIL irq_at_done irq=%b cycles=%0d exp=0", irq, c); end
        @(posedge PCLK); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq); end
        apb_write(32'h8, 32'h2000, e);
        @(posedge PCLK); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b exp=0", irq); end
        apb_write(32'h4, 32'h0000, e);
    endtask
`endif

    task automatic test_reset_midstream();
        logic e;
        logic [31:0] r;
        pix_ready = 1'b0;
        apb_write(32'h0, 32'h0C0C0C, e);
        apb_write(32'h0, 32'h0D0D0D, e);
        apb_write(32'h4, 32'h0201, e);
        checks++; if (busy !== 1'b1 || pix_valid !== 1'b1) begin errors++; $display("FAIL mid_stream busy=%b valid=%b exp=1/1", busy, pix_valid); end
        PRESERN = 1'b0;
        @(posedge PCLK); #1;
        PRESERN = 1'b1;
        checks++; if (busy !== 1'b0 || pix_valid !== 1'b0 || pix_last !== 1'b0 || pix_data !== 24'd0) begin errors++; $display("FAIL mid_reset busy=%b valid=%b last=%b data=%h exp=0/0/0/0", busy, pix_valid, pix_last, pix_data); end
        apb_read(32'h8, r);
        checks++; if (r !== 32'h0000_0100) begin errors++; $display("FAIL mid_reset_status got=%h exp=00000100", r); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overflow();
        test_underrun_stall();
        test_regs();
`ifdef WS_PIXSTREAM_IRQ_EN
        test_irq();
`endif
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
